// File: rtl/regfile_rat_pkg.sv
// Shared sizing constants and helpers for the architectural register file
// and its register alias table.
package regfile_rat_pkg;

  localparam int XLEN_DEF    = 32;
  localparam int REG_NUM_DEF = 32;
  localparam int TAG_W_DEF   = 5;
  localparam int REG_ADDR_W  = 5;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  // x0 is hardwired to zero, so only non-zero addresses carry state
  function automatic logic addr_live(input reg_addr_t addr);
    return addr != '0;
  endfunction

endpackage

// File: rtl/regfile_rat_if.sv
// Issue, lookup and commit signals between the pipeline and the register file.
interface regfile_rat_if
  import regfile_rat_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int TAG_W = TAG_W_DEF
);

  logic             issue_en;
  reg_addr_t        issue_rd;
  logic [TAG_W-1:0] issue_tag;

  reg_addr_t        rs1_addr;
  reg_addr_t        rs2_addr;
  logic             rs1_busy;
  logic             rs2_busy;
  logic [TAG_W-1:0] rs1_tag;
  logic [TAG_W-1:0] rs2_tag;
  logic [XLEN-1:0]  rs1_val;
  logic [XLEN-1:0]  rs2_val;

  logic             commit_en;
  logic [TAG_W-1:0] commit_tag;
  reg_addr_t        commit_rd;
  logic [XLEN-1:0]  commit_val;

  modport master (
    output issue_en, issue_rd, issue_tag, rs1_addr, rs2_addr,
           commit_en, commit_tag, commit_rd, commit_val,
    input  rs1_busy, rs2_busy, rs1_tag, rs2_tag, rs1_val, rs2_val
  );

  modport slave (
    input  issue_en, issue_rd, issue_tag, rs1_addr, rs2_addr,
           commit_en, commit_tag, commit_rd, commit_val,
    output rs1_busy, rs2_busy, rs1_tag, rs2_tag, rs1_val, rs2_val
  );

endinterface

// File: rtl/rat_lookup.sv
// One source-operand read port: x0 forcing and same-cycle commit bypass
// on top of the selected register's stored value, busy bit and tag.
module rat_lookup
  import regfile_rat_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int TAG_W = TAG_W_DEF
) (
  input  reg_addr_t        rs_addr,
  input  logic             commit_en,
  input  reg_addr_t        commit_rd,
  input  logic [TAG_W-1:0] commit_tag,
  input  logic [XLEN-1:0]  commit_val,
  input  logic [XLEN-1:0]  reg_val,
  input  logic             reg_busy,
  input  logic [TAG_W-1:0] reg_tag,
  output logic             rs_busy,
  output logic [TAG_W-1:0] rs_tag,
  output logic [XLEN-1:0]  rs_val
);

  // Bypass only when the retiring entry is the one the RAT still names
  always_comb begin
    rs_val  = reg_val;
    rs_busy = reg_busy;
    rs_tag  = reg_tag;
    if (!addr_live(rs_addr)) begin
      rs_val  = '0;
      rs_busy = 1'b0;
    end else if (commit_en && (commit_rd == rs_addr) && reg_busy &&
                 (reg_tag == commit_tag)) begin
      rs_val  = commit_val;
      rs_busy = 1'b0;
    end
  end

endmodule

// File: rtl/regfile_rat.sv
// Architectural register file with register alias table: retires ROB commits
// into the registers and tracks which ROB entry will produce each register.
module regfile_rat
  import regfile_rat_pkg::*;
#(
  parameter int XLEN    = XLEN_DEF,
  parameter int REG_NUM = REG_NUM_DEF,
  parameter int TAG_W   = TAG_W_DEF
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          rdy_in,
  input  logic          clear,
  regfile_rat_if.slave  bus
);

  logic [XLEN-1:0]    regs_q [REG_NUM];
  logic [XLEN-1:0]    regs_d [REG_NUM];
  logic [REG_NUM-1:0] busy_q;
  logic [REG_NUM-1:0] busy_d;
  logic [TAG_W-1:0]   tag_q  [REG_NUM];
  logic [TAG_W-1:0]   tag_d  [REG_NUM];

  // Later statements override earlier ones: clear beats issue beats commit
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    tag_d  = tag_q;
    if (rdy_in) begin
      if (bus.commit_en && addr_live(bus.commit_rd)) begin
        regs_d[bus.commit_rd] = bus.commit_val;
        if (busy_q[bus.commit_rd] && (tag_q[bus.commit_rd] == bus.commit_tag))
          busy_d[bus.commit_rd] = 1'b0;
      end
      if (bus.issue_en && addr_live(bus.issue_rd) && !clear) begin
        busy_d[bus.issue_rd] = 1'b1;
        tag_d[bus.issue_rd]  = bus.issue_tag;
      end
      if (clear)
        busy_d = '0;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      regs_q <= '{default: '0};
      busy_q <= '0;
      tag_q  <= '{default: '0};
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
      tag_q  <= tag_d;
    end
  end

  rat_lookup #(.XLEN(XLEN), .TAG_W(TAG_W)) u_rs1 (
    .rs_addr    (bus.rs1_addr),
    .commit_en  (bus.commit_en),
    .commit_rd  (bus.commit_rd),
    .commit_tag (bus.commit_tag),
    .commit_val (bus.commit_val),
    .reg_val    (regs_q[bus.rs1_addr]),
    .reg_busy   (busy_q[bus.rs1_addr]),
    .reg_tag    (tag_q[bus.rs1_addr]),
    .rs_busy    (bus.rs1_busy),
    .rs_tag     (bus.rs1_tag),
    .rs_val     (bus.rs1_val)
  );

  rat_lookup #(.XLEN(XLEN), .TAG_W(TAG_W)) u_rs2 (
    .rs_addr    (bus.rs2_addr),
    .commit_en  (bus.commit_en),
    .commit_rd  (bus.commit_rd),
    .commit_tag (bus.commit_tag),
    .commit_val (bus.commit_val),
    .reg_val    (regs_q[bus.rs2_addr]),
    .reg_busy   (busy_q[bus.rs2_addr]),
    .reg_tag    (tag_q[bus.rs2_addr]),
    .rs_busy    (bus.rs2_busy),
    .rs_tag     (bus.rs2_tag),
    .rs_val     (bus.rs2_val)
  );

endmodule

// File: tb/tb_regfile_rat.sv
// Scenario bench for regfile_rat: expected lookups are queued with each
// stimulus phase and compared on both read ports before the next edge.
module tb_regfile_rat;

  typedef struct {
    string       name;
    logic [4:0]  addr;
    logic        busy;
    logic [4:0]  tag;
    logic [31:0] val;
  } exp_t;

  logic clk;
  logic rst_n;
  logic rdy;
  logic clear;
  int   tests;
  int   fails;
  exp_t sb[$];
  exp_t e;

  regfile_rat_if bus ();

  regfile_rat dut (
    .clk_in (clk),
    .rst_in (rst_n),
    .rdy_in (rdy),
    .clear  (clear),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic ie, input logic [4:0] ird, input logic [4:0] itag,
                       input logic ce, input logic [4:0] crd, input logic [4:0] ctag,
                       input logic [31:0] cval, input logic cl, input logic rd_ok);
    bus.issue_en   = ie;
    bus.issue_rd   = ird;
    bus.issue_tag  = itag;
    bus.commit_en  = ce;
    bus.commit_rd  = crd;
    bus.commit_tag = ctag;
    bus.commit_val = cval;
    clear          = cl;
    rdy            = rd_ok;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic exp_push(input string n, input logic [4:0] a, input logic b,
                          input logic [4:0] t, input logic [31:0] v);
    exp_t x;
    x.name = n; x.addr = a; x.busy = b; x.tag = t; x.val = v;
    sb.push_back(x);
  endtask

  task automatic test_reset();
    for (int p = 0; p < 4; p++) begin
      @(negedge clk);
      case (p)
        0: begin idle(); exp_push("reset_hold_x5", 5, 0, 0, 0); exp_push("reset_hold_x0", 0, 0, 0, 0); end
        1: begin rst_n = 1'b1; drive(1, 5, 3, 1, 5, 0, 32'hAB, 0, 1); exp_push("pre_x5", 5, 0, 0, 0); end
        2: begin idle(); exp_push("loaded_x5", 5, 1, 3, 32'hAB); end
        default: begin @(posedge clk); #2; rst_n = 1'b0; exp_push("async_reset_x5", 5, 0, 0, 0); end
      endcase
      while (sb.size() != 0) begin
        e = sb.pop_front();
        bus.rs1_addr = e.addr; bus.rs2_addr = e.addr; #1;
        tests++;
        if (bus.rs1_busy !== e.busy || bus.rs2_busy !== e.busy || bus.rs1_val !== e.val ||
            bus.rs2_val !== e.val || (e.busy && (bus.rs1_tag !== e.tag || bus.rs2_tag !== e.tag))) begin
          fails++;
          $display("[TB] FAIL %s: got rs1 busy=%0b tag=%0d val=%h rs2 busy=%0b tag=%0d val=%h, want busy=%0b tag=%0d val=%h",
                   e.name, bus.rs1_busy, bus.rs1_tag, bus.rs1_val, bus.rs2_busy, bus.rs2_tag, bus.rs2_val, e.busy, e.tag, e.val);
        end
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_issue_commit();
    for (int p = 0; p < 4; p++) begin
      @(negedge clk);
      case (p)
        0: begin drive(1, 3, 7, 0, 0, 0, 0, 0, 1); exp_push("issue_pre_x3", 3, 0, 0, 0); end
        1: begin idle(); exp_push("issued_x3", 3, 1, 7, 0); end
        2: begin drive(0, 0, 0, 1, 3, 7, 32'hDEADBEEF, 0, 1); exp_push("bypass_x3", 3, 0, 0, 32'hDEADBEEF); end
        default: begin idle(); exp_push("retired_x3", 3, 0, 0, 32'hDEADBEEF); end
      endcase
      while (sb.size() != 0) begin
        e = sb.pop_front();
        bus.rs1_addr = e.addr; bus.rs2_addr = e.addr; #1;
        tests++;
        if (bus.rs1_busy !== e.busy || bus.rs2_busy !== e.busy || bus.rs1_val !== e.val ||
            bus.rs2_val !== e.val || (e.busy && (bus.rs1_tag !== e.tag || bus.rs2_tag !== e.tag))) begin
          fails++;
          $display("[TB] FAIL %s: got rs1 busy=%0b tag=%0d val=%h rs2 busy=%0b tag=%0d val=%h, want busy=%0b tag=%0d val=%h",
                   e.name, bus.rs1_busy, bus.rs1_tag, bus.rs1_val, bus.rs2_busy, bus.rs2_tag, bus.rs2_val, e.busy, e.tag, e.val);
        end
      end
    end
  endtask

  task automatic test_stale_commit();
    for (int p = 0; p < 6; p++) begin
      @(negedge clk);
      case (p)
        0: drive(1, 4, 2, 0, 0, 0, 0, 0, 1);
        1: begin drive(1, 4, 9, 0, 0, 0, 0, 0, 1); exp_push("first_owner_x4", 4, 1, 2, 0); end
        2: begin drive(0, 0, 0, 1, 4, 2, 32'h11, 0, 1); exp_push("stale_no_bypass_x4", 4, 1, 9, 0); end
        3: begin idle(); exp_push("stale_written_x4", 4, 1, 9, 32'h11); end
        4: begin drive(0, 0, 0, 1, 4, 9, 32'h22, 0, 1); exp_push("owner_bypass_x4", 4, 0, 0, 32'h22); end
        default: begin idle(); exp_push("owner_retired_x4", 4, 0, 0, 32'h22); end
      endcase
      while (sb.size() != 0) begin
        e = sb.pop_front();
        bus.rs1_addr = e.addr; bus.rs2_addr = e.addr; #1;
        tests++;
        if (bus.rs1_busy !== e.busy || bus.rs2_busy !== e.busy || bus.rs1_val !== e.val ||
            bus.rs2_val !== e.val || (e.busy && (bus.rs1_tag !== e.tag || bus.rs2_tag !== e.tag))) begin
          fails++;
          $display("[TB] FAIL %s: got rs1 busy=%0b tag=%0d val=%h rs2 busy=%0b tag=%0d val=%h, want busy=%0b tag=%0d val=%h",
                   e.name, bus.rs1_busy, bus.rs1_tag, bus.rs1_val, bus.rs2_busy, bus.rs2_tag, bus.rs2_val, e.busy, e.tag, e.val);
        end
      end
    end
  endtask

  task automatic test_same_cycle();
    for (int p = 0; p < 2; p++) begin
      @(negedge clk);
      case (p)
        0: begin drive(1, 6, 4, 1, 6, 1, 32'h55, 0, 1); exp_push("same_cycle_pre_x6", 6, 0, 0, 0); end
        default: begin idle(); exp_push("issue_wins_x6", 6, 1, 4, 32'h55); end
      endcase
      while (sb.size() != 0) begin
        e = sb.pop_front();
        bus.rs1_addr = e.addr; bus.rs2_addr = e.addr; #1;
        tests++;
        if (bus.rs1_busy !== e.busy || bus.rs2_busy !== e.busy || bus.rs1_val !== e.val ||
            bus.rs2_val !== e.val || (e.busy && (bus.rs1_tag !== e.tag || bus.rs2_tag !== e.tag))) begin
          fails++;
          $display("[TB] FAIL %s: got rs1 busy=%0b tag=%0d val=%h rs2 busy=%0b tag=%0d val=%h, want busy=%0b tag=%0d val=%h",
                   e.name, bus.rs1_busy, bus.rs1_tag, bus.rs1_val, bus.rs2_busy, bus.rs2_tag, bus.rs2_val, e.busy, e.tag, e.val);
        end
      end
    end
  endtask

  task automatic test_flush();
    for (int p = 0; p < 5; p++) begin
      @(negedge clk);
      case (p)
        0: drive(1, 1, 10, 0, 0, 0, 0, 0, 1);
        1: drive(1, 2, 11, 0, 0, 0, 0, 0, 1);
        2: drive(1, 3, 12, 0, 0, 0, 0, 0, 1);
        3: begin
          drive(1, 8, 13, 1, 2, 11, 32'h77, 1, 1);
          exp_push("preflush_x1", 1, 1, 10, 0);
          exp_push("flush_bypass_x2", 2, 0, 0, 32'h77);
          exp_push("preflush_x3", 3, 1, 12, 32'hDEADBEEF);
        end
        default: begin
          idle();
          exp_push("flushed_x1", 1, 0, 0, 0);
          exp_push("flush_commit_x2", 2, 0, 0, 32'h77);
          exp_push("flushed_x3", 3, 0, 0, 32'hDEADBEEF);
          exp_push("flush_drops_issue_x8", 8, 0, 0, 0);
        end
      endcase
      while (sb.size() != 0) begin
        e = sb.pop_front();
        bus.rs1_addr = e.addr; bus.rs2_addr = e.addr; #1;
        tests++;
        if (bus.rs1_busy !== e.busy || bus.rs2_busy !== e.busy || bus.rs1_val !== e.val ||
            bus.rs2_val !== e.val || (e.busy && (bus.rs1_tag !== e.tag || bus.rs2_tag !== e.tag))) begin
          fails++;
          $display("[TB] FAIL %s: got rs1 busy=%0b tag=%0d val=%h rs2 busy=%0b tag=%0d val=%h, want busy=%0b tag=%0d val=%h",
                   e.name, bus.rs1_busy, bus.rs1_tag, bus.rs1_val, bus.rs2_busy, bus.rs2_tag, bus.rs2_val, e.busy, e.tag, e.val);
        end
      end
    end
  endtask

  task automatic test_x0_stall();
    for (int p = 0; p < 5; p++) begin
      @(negedge clk);
      case (p)
        0: begin drive(1, 0, 5, 1, 0, 5, 32'hFFFF, 0, 1); exp_push("x0_write_pre", 0, 0, 0, 0); end
        1: begin drive(1, 9, 6, 0, 0, 0, 0, 0, 1); exp_push("x0_after_write", 0, 0, 0, 0); end
        2: begin
          drive(1, 7, 3, 1, 9, 6, 32'h33, 0, 0);
          exp_push("stall_bypass_x9", 9, 0, 0, 32'h33);
          exp_push("stall_pre_x7", 7, 0, 0, 0);
        end
        3: begin
          drive(0, 0, 0, 1, 4, 0, 32'h99, 0, 0);
          exp_push("stall_drops_issue_x7", 7, 0, 0, 0);
          exp_push("stall_drops_commit_x9", 9, 1, 6, 0);
          exp_push("stall_pre_x4", 4, 0, 0, 32'h22);
        end
        default: begin
          idle();
          exp_push("stall_commit_lost_x4", 4, 0, 0, 32'h22);
          exp_push("after_stall_x9", 9, 1, 6, 0);
        end
      endcase
      while (sb.size() != 0) begin
        e = sb.pop_front();
        bus.rs1_addr = e.addr; bus.rs2_addr = e.addr; #1;
        tests++;
        if (bus.rs1_busy !== e.busy || bus.rs2_busy !== e.busy || bus.rs1_val !== e.val ||
            bus.rs2_val !== e.val || (e.busy && (bus.rs1_tag !== e.tag || bus.rs2_tag !== e.tag))) begin
          fails++;
          $display("[TB] FAIL %s: got rs1 busy=%0b tag=%0d val=%h rs2 busy=%0b tag=%0d val=%h, want busy=%0b tag=%0d val=%h",
                   e.name, bus.rs1_busy, bus.rs1_tag, bus.rs1_val, bus.rs2_busy, bus.rs2_tag, bus.rs2_val, e.busy, e.tag, e.val);
        end
      end
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    bus.rs1_addr = '0;
    bus.rs2_addr = '0;
    idle();
    test_reset();
    test_issue_commit();
    test_stale_commit();
    test_same_cycle();
    test_flush();
    test_x0_stall();
    @(negedge clk);
    idle();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/regfile_rat.md
# regfile_rat

Architectural register file with a register alias table for the out-of-order RISC-V core. Sits directly downstream of the reorder buffer: it consumes the ROB commit stream (`en_commit`, ROB tag, rd, value) to retire results into 32 architectural registers. It also serves the issue stage by recording which ROB entry will produce each register and answering source-operand lookups as either a ready value or a pending ROB tag.

## Interface
Parameters:
- `XLEN`, 32, data width
- `REG_NUM`, 32, architectural registers; x0 hardwired to zero
- `TAG_W`, 5, ROB tag width (ROB depth 32)

Ports:
- `clk_in`  in  1  clock; the single clock of the block
- `rst_in`  in  1  asynchronous, active-low reset
- `rdy_in`  in  1  global stall; low freezes all state
- `clear`  in  1  pipeline flush on mispredict
- `issue_en`  in  1  issue stage allocates a ROB entry with a destination
- `issue_rd`  in  5  destination register of the issuing instruction
- `issue_tag`  in  TAG_W  ROB tag assigned to the issuing instruction
- `rs1_addr`, `rs2_addr`  in  5  source lookups from issue
- `rs1_busy`, `rs2_busy`  out  1  source pending in the ROB
- `rs1_tag`, `rs2_tag`  out  TAG_W  producing ROB tag; valid when busy
- `rs1_val`, `rs2_val`  out  XLEN  register value; valid when not busy
- `commit_en`  in  1  ROB retires a register-writing instruction
- `commit_tag`  in  TAG_W  ROB tag being retired
- `commit_rd`  in  5  destination of the retiring instruction
- `commit_val`  in  XLEN  result value

## Operation
- State: `regs[REG_NUM]` (XLEN), `busy[REG_NUM]` (1 bit), `tag[REG_NUM]` (TAG_W).
- Reset (`rst_in` low, asynchronous): all `regs`, `busy` and `tag` go to 0. Outputs, which are combinational, then read value 0, busy 0, tag 0.
- Commit, when `commit_en` and `commit_rd != 0`:
  - `regs[commit_rd] <= commit_val`.
  - `busy[commit_rd]` is cleared only if it is set and `tag[commit_rd] == commit_tag`.
  - Otherwise busy and tag are unchanged, because a younger producer owns the register.
- Issue, when `issue_en`, `issue_rd != 0` and not `clear`: `busy[issue_rd] <= 1` and `tag[issue_rd] <= issue_tag`.
- Issue and commit to the same rd in the same cycle: the issue wins on busy and tag, and the commit still writes `regs`.
- `clear`:
  - All `busy` bits are cleared at the next edge.
  - A commit in the same cycle still writes `regs`.
  - An issue in the same cycle is dropped.
  - `tag` contents are don't-care after a clear.
- Lookup for source `rsN`, combinational:
  - If `rsN_addr == 0`: value 0, busy 0.
  - Else if `commit_en`, `commit_rd == rsN_addr`, `busy[rsN_addr]` and `tag[rsN_addr] == commit_tag`: bypass, giving value `commit_val` and busy 0.
  - Else: `regs`, `busy` and `tag` of the addressed register.
- Lookups never see the same-cycle issue. An instruction with `rs1 == rd` reads the prior producer.
- `rdy_in` low: no state updates. Lookup outputs remain valid, and bypass still applies.
- Writes to x0 are ignored in every path.

## Timing
- Lookup latency: 0 cycles, combinational.
- Issue and commit take effect at the next rising edge of `clk_in` while `rdy_in` is high.
- A value committed in cycle N:
  - appears via bypass in cycle N;
  - appears from `regs` in cycle N+1 onward.
- Busy set in cycle N is visible to lookups from cycle N+1.
- Reset is asynchronous and takes effect immediately, mid-operation included. Release is synchronous to the first following edge.
- Priority when several events are asserted together: reset > `clear` (busy only) > issue > commit (for busy and tag).

## Structure
- Shared package `def.v`:
  - `` `InstSize `` and `` `RegAddrSize ``, which are already present;
  - a new `` `RobTagSize `` with value `TAG_W-1:0`;
  - constants `` `zero `` and `` `one ``.
- Sub-module `rat_lookup`: one read port holding the bypass and x0 logic, instantiated twice for rs1 and rs2.
- The top module owns the arrays and the update logic.
- Expected size is about 150–200 lines of RTL.

## Test plan
- **Reset:** drive `rst_in` low mid-cycle, then look up x5 → `rs1_val=0`, `rs1_busy=0`. No clock edge is needed for this.
- **Issue then commit:**
  - Issue rd=3, tag=7. The next cycle a lookup of x3 gives busy=1, tag=7.
  - Then commit tag=7, rd=3, val=0xDEADBEEF. The same-cycle lookup gives 0xDEADBEEF with busy=0.
  - The next cycle `regs[3]` reads 0xDEADBEEF.
- **Stale commit:**
  - Issue x4 with tag 2, then x4 with tag 9.
  - Commit tag 2, val=0x11 → `regs[4]=0x11`, and x4 stays busy with tag 9.
  - Commit tag 9, val=0x22 → busy=0, value 0x22.
- **Same-cycle issue and commit, rd=6:** commit tag 1, val=0x55, together with issue tag 4 → `regs[6]=0x55`, busy=1, tag=4.
- **Flush:**
  - Issue x1, x2, x3 with tags 10–12, then assert `clear` together with issue x8 tag 13.
  - All of x1, x2, x3 and x8 are then not busy, and their values are unchanged.
- **x0 and stall:**
  - Issue or commit to rd=0 → x0 reads 0, not busy.
  - With `rdy_in=0`, issue x7 → x7 is not busy after the edge.
